dct_tpose_pp: RTL and testbench
===============================

DCT_TPOSE_PP -- requirements
Module: dct_tpose_pp

Interface
REQ-001 SHALL have parameter N, default 8, block dimension; legal values 4, 8, 16.
REQ-002 SHALL have parameter W, default 12, sample width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  row-pass sample valid.
REQ-006 SHALL have port s_ready  output  1  block accepts a sample.
REQ-007 SHALL have port s_data  input  W  row-pass sample, row-major within block.
REQ-008 SHALL have port m_valid  output  1  column-pass sample valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts sample.
REQ-010 SHALL have port m_data  output  W  transposed sample.
REQ-011 SHALL have port m_first  output  1  high with first sample of an output block.
REQ-012 SHALL have port m_last  output  1  high with last sample of an output block.
REQ-013 SHALL have port blk_done  output  1  one-cycle pulse per completed output block.
REQ-014 SHALL have port blk_cnt  output  16  completed output block count.

Function
REQ-015 SHALL hold two banks of N*N words of W bits (ping-pong); write bank pointer wb, read bank pointer rb, per-bank full flags.
REQ-016 s_ready SHALL equal NOT full[wb]; a write occurs when s_valid AND s_ready.
REQ-017 Writes SHALL store to bank wb at index wcnt, wcnt counting 0..N*N-1, incrementing per write.
REQ-018 On the write with wcnt = N*N-1: set full[wb], toggle wb, wcnt to 0, same edge.
REQ-019 m_valid SHALL equal full[rb]; m_data SHALL be bank rb at index (rcnt mod N)*N + rcnt/N, i.e. column-major, combinational from stored words.
REQ-020 A read occurs when m_valid AND m_ready; rcnt increments 0..N*N-1.
REQ-021 On the read with rcnt = N*N-1: clear full[rb], toggle rb, rcnt to 0, blk_done high next cycle, blk_cnt increments next cycle, wrapping 0xFFFF to 0.
REQ-022 m_first SHALL be m_valid AND rcnt = 0; m_last SHALL be m_valid AND rcnt = N*N-1.
REQ-023 First sample of a block SHALL be valid the cycle after its last write (1-cycle latency).
REQ-024 Write completion on one bank and read completion on the other in the same cycle SHALL both take effect.
REQ-025 With m_ready held high, s_ready SHALL never deassert; sustained throughput one sample per cycle per side.
REQ-026 With m_ready held low, at most 2*N*N samples accepted; then s_ready low; m_valid and m_data held stable until a read occurs.

Reset
REQ-027 On rst: wcnt, rcnt, wb, rb, full flags, blk_cnt to 0; blk_done 0; hence s_ready 1, m_valid, m_first, m_last 0 the cycle after rst.
REQ-028 Reset mid-block SHALL discard partial and full banks; storage contents need not be reset.

Configuration
REQ-029 Macro DCT_TPOSE_BYPASS_EN defined: extra input bypass (1 bit); bypass sampled at the write with wcnt = 0 and stored per bank; when set for a bank its read order SHALL be row-major (index rcnt).
REQ-030 DCT_TPOSE_BYPASS_EN undefined: no bypass port; read order always column-major.

Verification (N=8, W=12)
REQ-031 Reset, write 0..63 with m_ready=1 -> m_data sequence 0,8,16,..,56,1,9,..,63; m_first on 0, m_last on 63; blk_done one pulse; blk_cnt=1.
REQ-032 Three back-to-back blocks, s_valid and m_ready always 1 -> s_ready never low, 192 outputs contiguous, blk_cnt=3.
REQ-033 m_ready=0, s_valid=1 -> exactly 128 writes accepted then s_ready=0; m_data held at 0; raise m_ready -> s_ready rises the cycle after the 64th read.
REQ-034 Assert rst after 30 writes -> next cycle s_ready=1, m_valid=0; fresh 64 writes yield a correct transposed block.
REQ-035 Align last write of bank 1 with last read of bank 0 -> bank 1 full, bank 0 free, m_valid stays 1, m_first next cycle.
REQ-036 With DCT_TPOSE_BYPASS_EN, bypass=1 at first write of 0..63 -> output 0,1,2,..,63.

Source files
------------

// File: rtl/dct_tpose_pp_if.sv
// Stream bundle for dct_tpose_pp: row-major input side and transposed output side.
// DCT_TPOSE_BYPASS_EN adds a per-block bypass input to the bundle.
interface dct_tpose_pp_if #(parameter int W = 12);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_first;
  logic         m_last;
`ifdef DCT_TPOSE_BYPASS_EN
  logic         bypass;

  modport master (output s_valid, s_data, bypass, m_ready,
                  input  s_ready, m_valid, m_data, m_first, m_last);
  modport slave  (input  s_valid, s_data, bypass, m_ready,
                  output s_ready, m_valid, m_data, m_first, m_last);
`else
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_first, m_last);
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_first, m_last);
`endif
endinterface

// File: rtl/dct_tpose_pp.sv
// Ping-pong N x N transpose buffer between DCT row and column passes.
// Optional feature macro: DCT_TPOSE_BYPASS_EN (per-block row-major read order).
module dct_tpose_pp #(
  parameter int N = 8,
  parameter int W = 12
) (
  input  logic        clk,
  input  logic        rst,
  dct_tpose_pp_if.slave bus,
  output logic        blk_done,
  output logic [15:0] blk_cnt
);
  localparam int DEPTH = N * N;
  localparam int LB    = $clog2(N);
  localparam int AW    = 2 * LB;

  logic [W-1:0]  mem [2][DEPTH];
  logic          wb, rb;
  logic [1:0]    full;
  logic [AW-1:0] wcnt, rcnt, ridx, tidx;
  logic          wr, rd, wlast, rlast;

  assign bus.s_ready = !full[wb];
  assign bus.m_valid = full[rb];
  assign wr          = bus.s_valid && bus.s_ready;
  assign rd          = bus.m_valid && bus.m_ready;
  assign wlast       = wcnt == AW'(DEPTH - 1);
  assign rlast       = rcnt == AW'(DEPTH - 1);

  // Column-major walk: swapping the row/column halves of rcnt gives (rcnt mod N)*N + rcnt/N.
  assign tidx = {rcnt[LB-1:0], rcnt[AW-1:LB]};

`ifdef DCT_TPOSE_BYPASS_EN
  logic [1:0] byp;
  assign ridx = byp[rb] ? rcnt : tidx;

  always_ff @(posedge clk) begin
    if (rst)                    byp     <= '0;
    else if (wr && wcnt == '0)  byp[wb] <= bus.bypass;
  end
`else
  assign ridx = tidx;
`endif

  assign bus.m_data  = mem[rb][ridx];
  assign bus.m_first = bus.m_valid && (rcnt == '0);
  assign bus.m_last  = bus.m_valid && rlast;

  // Storage has no reset; full flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr) mem[wb][wcnt] <= bus.s_data;
  end

  // wb != rb whenever both complete together, so the two full bits never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      rcnt     <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      full     <= '0;
      blk_done <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      blk_done <= 1'b0;
      if (wr) begin
        if (wlast) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wcnt     <= '0;
        end else begin
          wcnt     <= wcnt + 1'b1;
        end
      end
      if (rd) begin
        if (rlast) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          rcnt     <= '0;
          blk_done <= 1'b1;
          blk_cnt  <= blk_cnt + 16'd1;
        end else begin
          rcnt     <= rcnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dct_tpose_pp.sv
// Scoreboard bench for dct_tpose_pp: a block-level transpose model feeds an expected queue,
// an independent output monitor pops and compares on every output handshake.
module tb_dct_tpose_pp;
  localparam int N = 8;
  localparam int W = 12;
  localparam int D = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blk_done;
  logic [15:0] blk_cnt;

  always #5 clk = ~clk;

  dct_tpose_pp_if #(.W(W)) bus();

  dct_tpose_pp #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .blk_done(blk_done), .blk_cnt(blk_cnt)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] part[$];
  logic         blk_byp = 1'b0;
  exp_t         e_rd;
  exp_t         e_wr;
  int nvec = 0, nerr = 0;
  int blocks_out = 0, done_pulses = 0, reads = 0, stalls = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a full block of 64 row-major samples becomes its transpose (or itself on bypass).
  always @(negedge clk) begin
    if (!rst && bus.s_valid && bus.s_ready) begin
`ifdef DCT_TPOSE_BYPASS_EN
      if (part.size() == 0) blk_byp = bus.bypass;
`endif
      part.push_back(bus.s_data);
      if (part.size() == D) begin
        for (int i = 0; i < D; i++) begin
          int r, c;
          r = i % N;
          c = i / N;
          e_wr.d = blk_byp ? part[i] : part[r * N + c];
          e_wr.f = (i == 0);
          e_wr.l = (i == D - 1);
          sb.push_back(e_wr);
        end
        part.delete();
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (blk_done) done_pulses++;
      if (bus.m_valid && bus.m_ready) begin
        reads++;
        if (sb.size() == 0) begin
          check("unexpected_output", {bus.m_data, bus.m_first, bus.m_last}, 0);
        end else begin
          e_rd = sb.pop_front();
          check("out_sample", {bus.m_data, bus.m_first, bus.m_last}, e_rd);
          if (e_rd.l) blocks_out++;
        end
      end
    end
  end

  task automatic do_reset();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    part.delete();
    blocks_out  = 0;
    done_pulses = 0;
    reads       = 0;
  endtask

  task automatic send(input logic [W-1:0] v);
    int   t;
    logic hs;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    forever begin
      hs = bus.s_ready;
      @(posedge clk); #1;
      if (hs) break;
      stalls++;
      if (++t > 1000) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 || bus.m_valid) begin
      @(posedge clk); #1;
      if (++t > 3000) begin
        check("drain_timeout", sb.size(), 0);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int   acc, gaps, rd_cnt;
    logic seen, bad, mr, hs;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
`ifdef DCT_TPOSE_BYPASS_EN
    bus.bypass  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_first", bus.m_first, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_blk_done", blk_done, 0);

    // Ramp block: 0,8,16,... out; first sample visible the cycle after the last write
    bus.m_ready = 1'b1;
    for (int i = 0; i < D; i++) send(W'(i));
    check("lat_m_valid", bus.m_valid, 1);
    check("lat_m_first", bus.m_first, 1);
    check("lat_m_data", bus.m_data, 0);
    wait_drain();
    check("ramp_blk_cnt", blk_cnt, 1);
    check("ramp_done_pulses", done_pulses, 1);

    // Three back-to-back blocks with the sink always ready
    do_reset();
    bus.m_ready = 1'b1;
    stalls = 0;
    gaps   = 0;
    seen   = 1'b0;
    for (int i = 0; i < 3 * D; i++) begin
      send(W'($urandom));
      if (bus.m_valid) seen = 1'b1;
      else if (seen && reads < 3 * D) gaps++;
    end
    while (reads < 3 * D && gaps < 1000) begin
      @(posedge clk); #1;
      if (!bus.m_valid && reads < 3 * D) gaps++;
    end
    check("b2b_stalls", stalls, 0);
    check("b2b_gaps", gaps, 0);
    wait_drain();
    check("b2b_blk_cnt", blk_cnt, 3);

    // Sink stalled: two banks fill, then back-pressure; output held
    do_reset();
    bus.m_ready = 1'b0;
    acc = 0;
    bad = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = '0;
    for (int c = 0; c < 200; c++) begin
      hs = bus.s_ready;
      @(posedge clk); #1;
      if (hs) acc++;
      bus.s_data = W'(acc);
      if (bus.m_valid && bus.m_data !== '0) bad = 1'b1;
    end
    bus.s_valid = 1'b0;
    check("stall_accepted", acc, 2 * D);
    check("stall_s_ready", bus.s_ready, 0);
    check("stall_m_valid", bus.m_valid, 1);
    check("stall_data_held", bad, 0);
    bus.m_ready = 1'b1;
    rd_cnt = 0;
    bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      mr = bus.m_valid && bus.m_ready;
      @(posedge clk); #1;
      if (mr) rd_cnt++;
      if (rd_cnt < D && bus.s_ready) bad = 1'b1;
      if (rd_cnt == D) break;
    end
    check("release_early_ready", bad, 0);
    check("release_s_ready", bus.s_ready, 1);
    wait_drain();
    check("release_blk_cnt", blk_cnt, 2);

    // Reset mid-block discards the partial block
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 30; i++) send(W'($urandom));
    do_reset();
    check("midrst_s_ready", bus.s_ready, 1);
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_blk_cnt", blk_cnt, 0);
    for (int i = 0; i < D; i++) send(W'($urandom));
    wait_drain();
    check("midrst_blocks", blocks_out, 1);

    // Last write of bank 1 coincides with last read of bank 0
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 2 * D; i++) send(W'($urandom));
    check("align_reads", reads, D);
    check("align_m_valid", bus.m_valid, 1);
    check("align_m_first", bus.m_first, 1);
    check("align_s_ready", bus.s_ready, 1);
    wait_drain();

`ifdef DCT_TPOSE_BYPASS_EN
    // Bypass block reads row-major, the following block is transposed again
    do_reset();
    bus.m_ready = 1'b1;
    bus.bypass  = 1'b1;
    send(W'(0));
    bus.bypass  = 1'b0;
    for (int i = 1; i < D; i++) send(W'(i));
    for (int i = 0; i < D; i++) send(W'($urandom));
    wait_drain();
    check("byp_blocks", blocks_out, 2);
`endif

    // Random valid/ready traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.s_valid = ($urandom_range(0, 9) < 7);
      bus.s_data  = W'($urandom);
      bus.m_ready = ($urandom_range(0, 9) < 6);
`ifdef DCT_TPOSE_BYPASS_EN
      bus.bypass  = $urandom_range(0, 1) == 1;
`endif
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_drain();
    check("rand_blk_cnt", blk_cnt, 16'(blocks_out));
    check("rand_done_pulses", done_pulses, blocks_out);
    check("rand_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
